// File: rtl/wb_arbiter2.sv
// Two-master Wishbone B4 pipelined bus arbiter.
// One master owns the shared bus for a whole tenure (cyc high); the arbiter
// tracks outstanding strobes so the owner can never have more than MAX_OUT
// unacknowledged requests, and aborts cleanly when cyc drops early or rst hits.
//
// Handshake: a strobe is accepted on a rising edge where s_stb=1 and
// s_stall=0; a response (ack or err) retires one outstanding strobe. The owner
// sees stall=1 whenever the slave stalls or the outstanding window is full.
module wb_arbiter2 #(
    parameter int   MAX_OUT    = 4,
    parameter logic FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (instruction side)
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_m,
    output logic [31:0] m0_dat_s,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m0_stall,
    // master 1 (data side)
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_m,
    output logic [31:0] m1_dat_s,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        m1_stall,
    // shared downstream bus
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_m,
    input  logic [31:0] s_dat_s,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic        s_stall,
    // ownership and debug visibility
    output logic [1:0]  gnt,
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_gnt_q, last_gnt_d;   // 0 = m0 was last owner, 1 = m1

    logic        full;
    logic        resp_ok;
    logic        own_cyc;
    logic        accept;
    logic        retire;

    assign full      = (cnt_q == MAX_CNT);
    // Responses with nothing outstanding are stray and must be dropped.
    assign resp_ok   = (cnt_q != 4'd0);
    assign own_cyc   = (state_q == OWN1) ? m1_cyc : m0_cyc;
    assign accept    = s_stb & ~s_stall;
    assign retire    = (s_ack | s_err) & resp_ok;
    assign m0_dat_s  = s_dat_s;
    assign m1_dat_s  = s_dat_s;
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

    // Bus multiplexing and per-master response routing for the current owner.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = 4'd0;
        s_adr    = 32'd0;
        s_dat_m  = 32'd0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_stall = 1'b1;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_stall = 1'b1;
        gnt      = 2'b00;
        case (state_q)
            OWN0: begin
                gnt      = 2'b01;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb & ~full;
                s_we     = m0_we;
                s_sel    = m0_sel;
                s_adr    = m0_adr;
                s_dat_m  = m0_dat_m;
                m0_ack   = s_ack & resp_ok;
                m0_err   = s_err & resp_ok;
                m0_stall = s_stall | full;
            end
            OWN1: begin
                gnt      = 2'b10;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb & ~full;
                s_we     = m1_we;
                s_sel    = m1_sel;
                s_adr    = m1_adr;
                s_dat_m  = m1_dat_m;
                m1_ack   = s_ack & resp_ok;
                m1_err   = s_err & resp_ok;
                m1_stall = s_stall | full;
            end
            default: ;
        endcase
    end

    // Next-state: arbitration in IDLE, tenure tracking and outstanding count.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (m0_cyc && m1_cyc) begin
                    state_d = (FIXED_PRIO || last_gnt_q) ? OWN0 : OWN1;
                end else if (m0_cyc) begin
                    state_d = OWN0;
                end else if (m1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    // Normal end or abort: outstanding responses are forgotten.
                    state_d    = IDLE;
                    cnt_d      = 4'd0;
                    last_gnt_d = (state_q == OWN1);
                end else if (accept && !retire) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (retire && !accept) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers with synchronous reset; m1 counts as last owner so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: vector table for arbitration/counter behaviour,
// plus hand sequences for grant latency, field muxing and address streaming.
module tb_wb_arbiter2;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_dat_m, m0_dat_s;
    logic        m0_ack, m0_err, m0_stall;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_dat_m, m1_dat_s;
    logic        m1_ack, m1_err, m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_dat_m, s_dat_s;
    logic        s_ack, s_err, s_stall;
    logic [1:0]  gnt;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // inputs:   {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_stall}
    // expected: {gnt[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err,
    //            m0_stall, m1_stall, cnt[3:0]}
    typedef struct {
        logic [7:0]  in;
        logic [13:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [13:0] exp_q[$];
    logic [31:0] adr_q[$];

    localparam logic [13:0] IDLE_EXP = 14'b00_00_00_00_11_0000;

    wb_arbiter2 #(.MAX_OUT(4), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_adr(m0_adr), .m0_dat_m(m0_dat_m), .m0_dat_s(m0_dat_s),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_adr(m1_adr), .m1_dat_m(m1_dat_m), .m1_dat_s(m1_dat_s),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_dat_m(s_dat_m), .s_dat_s(s_dat_s),
        .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall),
        .gnt(gnt), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] i, input logic [13:0] e);
        vec_t v;
        v.in  = i;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // driver: one vector per clock, outputs compared at the falling edge
    task automatic apply(input int idx);
        logic [13:0] e;
        logic [13:0] act;
        {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_err, s_stall} = vecs[idx].in;
        m0_adr  = $urandom;
        m1_adr  = $urandom;
        s_dat_s = $urandom;
        exp_q.push_back(vecs[idx].exp);
        @(negedge clk);
        e   = exp_q.pop_front();
        act = {gnt, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, m0_stall, m1_stall, dbg_cnt};
        check($sformatf("vec%0d", idx), {18'd0, act}, {18'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic fill_table();
        // reset state, slave ack ignored
        add(8'b1_00_00_1_0_0, IDLE_EXP);
        // single m0 request, one strobe, ack, end of tenure
        add(8'b0_11_00_0_0_0, IDLE_EXP);
        add(8'b0_11_00_0_0_0, 14'b01_11_00_00_01_0000);
        add(8'b0_10_00_1_0_0, 14'b01_10_10_00_01_0001);
        add(8'b0_00_00_0_0_0, 14'b01_00_00_00_01_0000);
        // reset, then tie: m0 first, one idle cycle, then m1, then m0 again
        add(8'b1_00_00_0_0_0, IDLE_EXP);
        add(8'b0_10_10_0_0_0, IDLE_EXP);
        add(8'b0_10_10_0_0_0, 14'b01_10_00_00_01_0000);
        add(8'b0_00_10_0_0_0, 14'b01_00_00_00_01_0000);
        add(8'b0_00_10_0_0_0, IDLE_EXP);
        add(8'b0_00_11_0_0_0, 14'b10_11_00_00_10_0000);
        add(8'b0_10_10_0_0_0, 14'b10_10_00_00_10_0001);
        add(8'b0_10_00_0_0_0, 14'b10_00_00_00_10_0001);
        add(8'b0_10_10_0_0_0, IDLE_EXP);
        add(8'b0_10_10_0_0_0, 14'b01_10_00_00_01_0000);
        // m0 re-requests in the idle cycle while m1 waits: m1 wins
        add(8'b0_00_10_0_0_0, 14'b01_00_00_00_01_0000);
        add(8'b0_10_10_0_0_0, IDLE_EXP);
        add(8'b0_10_10_0_0_0, 14'b10_10_00_00_10_0000);
        add(8'b0_10_00_0_0_0, 14'b10_00_00_00_10_0000);
        add(8'b0_00_00_0_0_0, IDLE_EXP);
        add(8'b0_00_00_0_0_0, IDLE_EXP);
        // outstanding window: 4 accepted, then stalled, ack frees a slot
        add(8'b0_11_00_0_0_0, IDLE_EXP);
        add(8'b0_11_00_0_0_0, 14'b01_11_00_00_01_0000);
        add(8'b0_11_00_0_0_0, 14'b01_11_00_00_01_0001);
        add(8'b0_11_00_0_0_0, 14'b01_11_00_00_01_0010);
        add(8'b0_11_00_0_0_0, 14'b01_11_00_00_01_0011);
        add(8'b0_11_00_0_0_0, 14'b01_10_00_00_11_0100);
        add(8'b0_11_00_1_0_0, 14'b01_10_10_00_11_0100);
        add(8'b0_11_00_0_0_0, 14'b01_11_00_00_01_0011);
        // drain; same-cycle accept+ack at 2; err retires; stray ack at 0
        add(8'b0_10_00_1_0_0, 14'b01_10_10_00_11_0100);
        add(8'b0_10_00_1_0_0, 14'b01_10_10_00_01_0011);
        add(8'b0_11_00_1_0_0, 14'b01_11_10_00_01_0010);
        add(8'b0_10_00_0_1_0, 14'b01_10_00_10_01_0010);
        add(8'b0_10_00_1_0_0, 14'b01_10_10_00_01_0001);
        add(8'b0_10_00_1_0_0, 14'b01_10_00_00_01_0000);
        add(8'b0_10_00_0_0_0, 14'b01_10_00_00_01_0000);
        // slave stall blocks accept
        add(8'b0_11_00_0_0_1, 14'b01_11_00_00_11_0000);
        add(8'b0_00_00_0_0_0, 14'b01_00_00_00_01_0000);
        // m1 abort with 3 outstanding, late ack discarded
        add(8'b0_00_11_0_0_0, IDLE_EXP);
        add(8'b0_00_11_0_0_0, 14'b10_11_00_00_10_0000);
        add(8'b0_00_11_0_0_0, 14'b10_11_00_00_10_0001);
        add(8'b0_00_11_0_0_0, 14'b10_11_00_00_10_0010);
        add(8'b0_00_00_0_0_0, 14'b10_00_00_00_10_0011);
        add(8'b0_00_00_1_0_0, IDLE_EXP);
        // reset mid-tenure in OWN1, then m0 wins the tie
        add(8'b0_00_11_0_0_0, IDLE_EXP);
        add(8'b0_00_11_0_0_0, 14'b10_11_00_00_10_0000);
        add(8'b1_00_11_0_0_0, 14'b10_11_00_00_10_0001);
        add(8'b0_10_10_1_0_0, IDLE_EXP);
        add(8'b0_10_10_0_0_0, 14'b01_10_00_00_01_0000);
        add(8'b0_00_00_0_0_0, 14'b01_00_00_00_01_0000);
    endtask

    initial begin
        int lat;
        logic found;
        logic [31:0] e_adr;

        rst = 1'b1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0;
        m0_adr = 32'd0; m0_dat_m = 32'd0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0;
        m1_adr = 32'd0; m1_dat_m = 32'd0;
        s_dat_s = 32'd0; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fill_table();
        for (int i = 0; i < vecs.size(); i++) apply(i);

        // grant latency and field muxing from m1 (m0 fields must be ignored)
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hc;
        m1_adr = 32'h0000_0200; m1_dat_m = 32'hdead_beef;
        m0_adr = 32'h0000_0100; m0_dat_m = 32'h1234_5678; m0_sel = 4'h3; m0_we = 1'b0;
        s_dat_s = 32'hcafe_f00d;
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_cyc) begin
                found = 1'b1;
                break;
            end
            lat++;
            @(posedge clk);
            #1;
        end
        check("m1_latency", lat, 1);
        check("m1_s_adr", s_adr, 32'h0000_0200);
        check("m1_s_dat_m", s_dat_m, 32'hdead_beef);
        check("m1_s_sel_we", {27'd0, s_sel, s_we}, {27'd0, 4'hc, 1'b1});
        check("m1_gnt", {30'd0, gnt}, 32'd2);
        check("m0_dat_s_pass", m0_dat_s, 32'hcafe_f00d);
        check("m1_dat_s_pass", m1_dat_s, 32'hcafe_f00d);
        if (found) begin
            @(posedge clk);
            #1;
        end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        @(posedge clk);
        #1;

        // m0 streams random addresses; every address must reach the slave
        m0_cyc = 1'b1; m0_stb = 1'b0; s_ack = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            m0_stb = 1'b1;
            m0_adr = $urandom;
            m1_adr = $urandom;
            m1_cyc = 1'($urandom_range(0, 1));
            adr_q.push_back(m0_adr);
            @(negedge clk);
            e_adr = adr_q.pop_front();
            check($sformatf("m0_stream_adr%0d", k), s_adr, e_adr);
            check($sformatf("m0_stream_stb%0d", k), {30'd0, s_stb, m1_stall}, {30'd0, 1'b1, 1'b1});
            @(posedge clk);
            #1;
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; s_ack = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("final_idle_gnt", {30'd0, gnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 Parameter MAX_OUT, default 4, meaning: maximum outstanding (accepted, unacknowledged) strobes per bus tenure, range 1..15.
REQ-002 Parameter FIXED_PRIO, default 1'b0, meaning: 1 = m0 always wins ties; 0 = round-robin between m0 and m1.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0  wb_if.slave  -  upstream master port 0 (instruction side).
REQ-006 m1  wb_if.slave  -  upstream master port 1 (data side).
REQ-007 s  wb_if.master  -  shared downstream Wishbone B4 pipelined bus.
REQ-008 Interface fields used: cyc, stb, we, sel[3:0], adr[31:0], dat_m[31:0] (master to slave), dat_s[31:0], ack, err, stall.
REQ-009 gnt  output  2  one-hot current owner (bit0 = m0, bit1 = m1); 2'b00 when idle.

Function
REQ-010 FSM states: IDLE, OWN0, OWN1; gnt SHALL be 01 in OWN0, 10 in OWN1 and 00 in IDLE.
REQ-011 IDLE: if only mX.cyc=1, go to OWNX next cycle; if neither, stay in IDLE.
REQ-012 IDLE with both cyc=1: FIXED_PRIO=1 -> OWN0; FIXED_PRIO=0 -> the master not granted last (last_gnt register) wins.
REQ-013 Arbitration latency: exactly 1 cycle from mX.cyc rising in IDLE to s.cyc=1.
REQ-014 OWNX: s.cyc, s.stb, s.we, s.sel, s.adr and s.dat_m SHALL be combinationally driven from mX; the non-owner's fields are ignored.
REQ-015 OWNX: mX.dat_s, mX.ack and mX.err SHALL follow s; mX.stall = s.stall OR (cnt == MAX_OUT).
REQ-016 s.stb SHALL be masked to 0 while cnt == MAX_OUT.
REQ-017 Non-owner: stall=1, ack=0, err=0, dat_s=s.dat_s. In IDLE both masters see stall=1.
REQ-018 Outstanding counter cnt, width 4: +1 on accept (s.stb & !s.stall), -1 on s.ack|s.err; both in the same cycle -> unchanged.
REQ-019 cnt SHALL never exceed MAX_OUT and never underflow; ack/err with cnt=0 is ignored (no decrement) and not forwarded.
REQ-020 Tenure end: in OWNX with mX.cyc=0 and cnt=0 -> IDLE next cycle; last_gnt <= X.
REQ-021 Abort: in OWNX with mX.cyc=0 and cnt>0 -> cnt cleared to 0, IDLE next cycle, late ack/err discarded.
REQ-022 Owner keeps the bus for as long as mX.cyc=1; there is no preemption.
REQ-023 Back-to-back requests: m1 waiting while m0 ends tenure -> IDLE for exactly 1 cycle, then OWN1.
REQ-024 Same master re-requesting in the IDLE cycle with the other waiting (FIXED_PRIO=0) -> other master wins.

Reset
REQ-025 rst=1 -> state IDLE, gnt=00, cnt=0, last_gnt=m1 (so m0 wins the first tie), s.cyc=0, s.stb=0, both masters stall=1, ack=0, err=0.
REQ-026 rst during a tenure aborts it on the next edge; slave responses arriving afterward are discarded.
REQ-027 No output SHALL be X after the first clock edge with rst=1.

Verification
REQ-028 Reset, then m0.cyc=stb=1, adr=0x100 -> s.cyc=1 one cycle later, gnt=01; slave ack -> m0.ack=1 same cycle, m1.ack=0.
REQ-029 Both masters raise cyc in the same cycle, FIXED_PRIO=0 -> OWN0 first; after m0 drops cyc -> 1 IDLE cycle, then OWN1; next tie -> OWN0 again.
REQ-030 Slave never acks, m0 issues 6 strobes with MAX_OUT=4 -> 4 accepted, then m0.stall=1 and s.stb=0; one ack -> 5th strobe accepted on the next unstalled cycle.
REQ-031 Same-cycle accept and ack at cnt=2 -> cnt stays 2; ack with cnt=0 -> no m0.ack, cnt stays 0.
REQ-032 m1 drops cyc with cnt=3 -> next cycle IDLE, cnt=0; a subsequent slave ack -> no ack to either master.
REQ-033 rst asserted mid-tenure in OWN1 -> next cycle gnt=00, s.cyc=0, cnt=0, m0 wins the following tie.
